// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with selectable round-robin or fixed-priority
// arbitration, a registered output stage and a wrapping output-transfer counter.
module rr_stream_mux #(
  parameter int unsigned IN    = 4,
  parameter int unsigned DATA  = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN*DATA-1:0]     in_data,
  input  logic [IN-1:0]          in_valid,
  output logic [IN-1:0]          in_ready,
  output logic [DATA-1:0]        out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(IN)-1:0]  out_sel,
  output logic [CNT_W-1:0]       out_count
);

  localparam int unsigned SEL_W = $clog2(IN);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] nxt_ptr;
  logic [IN-1:0]    grant;
  logic [DATA-1:0]  sel_data;
  logic             gnt_any;
  logic             load_en;
  logic             xfer_in;
  logic             xfer_out;
  int unsigned      start;
  int unsigned      idx;

  // Cyclic search from the start index; fixed priority always starts at channel 0.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    nxt_ptr  = '0;
    sel_data = '0;
    gnt_any  = 1'b0;
    idx      = 0;
    start    = (MODE == 1) ? 0 : int'(ptr_q);
    for (int unsigned k = 0; k < IN; k++) begin
      idx = (start + k) % IN;
      if (!gnt_any && in_valid[SEL_W'(idx)]) begin
        gnt_any  = 1'b1;
        gnt_idx  = SEL_W'(idx);
        nxt_ptr  = SEL_W'((idx + 1) % IN);
        sel_data = in_data[idx*DATA +: DATA];
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = grant & {IN{load_en}};
  assign xfer_in  = gnt_any && load_en;
  assign xfer_out = out_valid && out_ready;

  // Output register, transfer counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_count <= '0;
      ptr_q     <= '0;
    end else begin
      if (xfer_out) out_count <= out_count + CNT_W'(1);
      if (xfer_in) begin
        out_data  <= sel_data;
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
        if (MODE == 0) ptr_q <= nxt_ptr;
      end else if (xfer_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench: round-robin, fixed-priority and 4-bit-counter
// instances share one stimulus set; each task checks the instance it targets.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1, rdy2;
  logic [7:0]  dat0, dat1, dat2;
  logic        vld0, vld1, vld2;
  logic [1:0]  sel0, sel1, sel2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.IN(4), .DATA(8), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .out_data(dat0), .out_valid(vld0), .out_ready(out_ready), .out_sel(sel0), .out_count(cnt0));
  rr_stream_mux #(.IN(4), .DATA(8), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .out_data(dat1), .out_valid(vld1), .out_ready(out_ready), .out_sel(sel1), .out_count(cnt1));
  rr_stream_mux #(.IN(4), .DATA(8), .MODE(0), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
    .out_data(dat2), .out_valid(vld2), .out_ready(out_ready), .out_sel(sel2), .out_count(cnt2));

  // Advance one edge; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0; in_data = 32'h0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) rst_n = 1'b1;
      tick();
      #1;
      total++;
      if ({vld0, dat0, sel0, cnt0, rdy0} !== 31'h0)
        $display("FAIL reset_idle cyc%0d: valid=%b data=%h sel=%0d count=%0d ready=%b, want all zero",
                 c, vld0, dat0, sel0, cnt0, rdy0);
      else passed++;
    end
  endtask

  task automatic test_rr_fairness();
    logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    in_data = 32'hDDCCBBAA; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    total++;
    if (rdy0 !== 4'b0001 || vld0 !== 1'b0)
      $display("FAIL rr_first_grant: ready=%b valid=%b, want 0001 0", rdy0, vld0);
    else passed++;
    for (int b = 0; b < 8; b++) begin
      tick();
      if (b == 7) in_valid = 4'b0000;
      #1;
      total++;
      if (vld0 !== 1'b1 || sel0 !== 2'(b % 4) || dat0 !== exp_d[b % 4])
        $display("FAIL rr_beat%0d: valid=%b sel=%0d data=%h, want 1 %0d %h",
                 b, vld0, sel0, dat0, b % 4, exp_d[b % 4]);
      else passed++;
      if (b < 7) begin
        total++;
        if (rdy0 !== 4'(1 << ((b + 1) % 4)))
          $display("FAIL rr_ready%0d: ready=%b, want %b", b, rdy0, 4'(1 << ((b + 1) % 4)));
        else passed++;
      end
    end
    tick();
    total++;
    if (cnt0 !== 16'd8 || vld0 !== 1'b0)
      $display("FAIL rr_count: count=%0d valid=%b, want 8 0", cnt0, vld0);
    else passed++;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    in_data = 32'hDDCCBBAA; in_valid = 4'b1111; out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      total++;
      if (rdy1 !== 4'b0001)
        $display("FAIL fp_ready%0d: ready=%b, want 0001", b, rdy1);
      else passed++;
      tick();
      total++;
      if (vld1 !== 1'b1 || sel1 !== 2'd0 || dat1 !== 8'hAA)
        $display("FAIL fp_beat%0d: valid=%b sel=%0d data=%h, want 1 0 aa", b, vld1, sel1, dat1);
      else passed++;
    end
    in_valid = 4'b1110;
    #1;
    total++;
    if (rdy1 !== 4'b0010)
      $display("FAIL fp_drop_ready: ready=%b, want 0010", rdy1);
    else passed++;
    tick();
    in_valid = 4'b0000;
    total++;
    if (vld1 !== 1'b1 || sel1 !== 2'd1 || dat1 !== 8'hBB)
      $display("FAIL fp_drop_beat: valid=%b sel=%0d data=%h, want 1 1 bb", vld1, sel1, dat1);
    else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data = 32'h00CC0000; in_valid = 4'b0100; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (vld0 !== 1'b1 || dat0 !== 8'hCC || sel0 !== 2'd2 || rdy0 !== 4'b0000 || cnt0 !== 16'd0)
        $display("FAIL bp_stall%0d: valid=%b data=%h sel=%0d ready=%b count=%0d, want 1 cc 2 0000 0",
                 c, vld0, dat0, sel0, rdy0, cnt0);
      else passed++;
      tick();
    end
    out_ready = 1'b1; in_valid = 4'b0000;
    tick();
    tick();
    total++;
    if (cnt0 !== 16'd1 || vld0 !== 1'b0)
      $display("FAIL bp_release: count=%0d valid=%b, want 1 0", cnt0, vld0);
    else passed++;
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    in_data = 32'h44332211; in_valid = 4'b1000; out_ready = 1'b1;
    #1;
    total++;
    if (rdy0 !== 4'b1000) $display("FAIL wrap_ready3: ready=%b, want 1000", rdy0);
    else passed++;
    tick();
    in_valid = 4'b0101;
    #1;
    total++;
    if (sel0 !== 2'd3 || dat0 !== 8'h44 || rdy0 !== 4'b0001)
      $display("FAIL wrap_ch3: sel=%0d data=%h ready=%b, want 3 44 0001", sel0, dat0, rdy0);
    else passed++;
    tick();
    in_valid = 4'b0100;
    #1;
    total++;
    if (sel0 !== 2'd0 || dat0 !== 8'h11 || rdy0 !== 4'b0100)
      $display("FAIL wrap_ch0: sel=%0d data=%h ready=%b, want 0 11 0100", sel0, dat0, rdy0);
    else passed++;
    tick();
    in_valid = 4'b0000;
    total++;
    if (sel0 !== 2'd2 || dat0 !== 8'h33)
      $display("FAIL wrap_ch2: sel=%0d data=%h, want 2 33", sel0, dat0);
    else passed++;
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_data = 32'h000000A5; in_valid = 4'b0001; out_ready = 1'b0;
    tick();
    in_valid = 4'b0000; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (vld0 !== 1'b0 || cnt0 !== 16'd0 || dat0 !== 8'h00)
      $display("FAIL midreset: valid=%b count=%0d data=%h, want 0 0 00", vld0, cnt0, dat0);
    else passed++;
    in_valid = 4'b1111;
    #1;
    total++;
    if (rdy0 !== 4'b0001) $display("FAIL midreset_ptr: ready=%b, want 0001", rdy0);
    else passed++;
    in_valid = 4'b0000;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    in_data = 32'h00000011; in_valid = 4'b0001; out_ready = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 17) in_valid = 4'b0000;
    end
    total++;
    if (cnt2 !== 4'd0 || cnt0 !== 16'd16)
      $display("FAIL cnt_wrap16: cnt4=%0d cnt16=%0d, want 0 16", cnt2, cnt0);
    else passed++;
    tick();
    total++;
    if (cnt2 !== 4'd1 || cnt0 !== 16'd17 || vld2 !== 1'b0)
      $display("FAIL cnt_wrap17: cnt4=%0d cnt16=%0d valid=%b, want 1 17 0", cnt2, cnt0, vld2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_pointer_wrap();
    test_reset_midstream();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
